// File: rtl/sha_result_hex_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha_fmt_pkg
//  Description : Shared ASCII constants, hex-digit helpers and the line
//                formatter state encoding for sha_result_hex_tx.
//  Revision    : 1.0  initial release
// ============================================================================
package sha_fmt_pkg;

    localparam logic [7:0] c_ASCII_SP = 8'h20;
    localparam logic [7:0] c_ASCII_CR = 8'h0D;
    localparam logic [7:0] c_ASCII_LF = 8'h0A;

    localparam int c_ID_BITS   = 32;
    localparam int c_ID_DIGITS = 8;

    // Number of hex digits needed to print a field of the given width
    function automatic int hex_digits(input int bits);
        return (bits + 3) / 4;
    endfunction

    // Lowercase ASCII hex character for one nibble
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] chr;
        if (nib < 4'd10) chr = 8'h30 + {4'h0, nib};
        else             chr = 8'h57 + {4'h0, nib};   // 'a' - 10
        return chr;
    endfunction

    // Line formatter states, in the order the fields are printed
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ID   = 3'd1,
        ST_SP1  = 3'd2,
        ST_LEN  = 3'd3,
        ST_SP2  = 3'd4,
        ST_SHA  = 3'd5,
        ST_CR   = 3'd6,
        ST_LF   = 3'd7
    } fmt_state_t;

endpackage
`default_nettype wire

// File: rtl/sha_result_hex_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha_result_hex_tx_if
//  Description : Digest record input strobe plus the ASCII byte stream.
//                slave = formatter side, master = producer/sink side.
//  Revision    : 1.0  initial release
// ============================================================================
interface sha_result_hex_tx_if #(
    parameter int SHA_BITS = 256,
    parameter int LEN_BITS = 61
);
    logic                ivalid;
    logic [31:0]         iid;
    logic [LEN_BITS-1:0] ilen;
    logic [SHA_BITS-1:0] isha;
    logic                m_tvalid;
    logic                m_tready;
    logic [7:0]          m_tdata;
    logic                m_tlast;

    modport slave (
        input  ivalid, iid, ilen, isha, m_tready,
        output m_tvalid, m_tdata, m_tlast
    );

    modport master (
        output ivalid, iid, ilen, isha, m_tready,
        input  m_tvalid, m_tdata, m_tlast
    );
endinterface
`default_nettype wire

// File: rtl/sha_result_hex_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sha_result_fifo
//  Description : Synchronous record FIFO, 2**DEPTH_LOG2 entries. Read data is
//                registered and valid on the cycle after a pop.
//  Revision    : 1.0  initial release
// ============================================================================
module sha_result_fifo #(
    parameter int WIDTH      = 349,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wptr;
    logic [DEPTH_LOG2:0] r_rptr;
    logic [WIDTH-1:0]    r_rdata;
    logic                w_wr;
    logic                w_rd;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                   (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
    assign empty = (r_wptr == r_rptr);
    assign w_wr  = push & ~full;
    assign w_rd  = pop & ~empty;
    assign rdata = r_rdata;

    // Storage array, written only when space is available
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= wdata;
    end

    // Pointer bookkeeping and registered head read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) begin
                r_rdata <= r_mem[r_rptr[DEPTH_LOG2-1:0]];
                r_rptr  <= r_rptr + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/sha_result_hex_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sha_result_hex_tx
//  Description : Buffers sha core result records and prints each one as a
//                lowercase-hex ASCII line "id len sha\r\n" on a byte stream.
//  Revision    : 1.0  initial release
// ============================================================================
module sha_result_hex_tx
    import sha_fmt_pkg::*;
#(
    parameter int SHA_BITS   = 256,
    parameter int LEN_BITS   = 61,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rstn,
    sha_result_hex_tx_if.slave  bus,
    output logic                overflow,
    output logic [15:0]         drop_cnt
);
    localparam int LEN_DIG  = hex_digits(LEN_BITS);
    localparam int SHA_DIG  = hex_digits(SHA_BITS);
    localparam int LEN_PAD  = LEN_DIG * 4;
    localparam int REC_BITS = c_ID_BITS + LEN_BITS + SHA_BITS;
    localparam int SHR_BITS = c_ID_BITS + LEN_PAD + SHA_BITS;
    localparam int MAX_DIG  = (SHA_DIG > LEN_DIG) ? ((SHA_DIG > c_ID_DIGITS) ? SHA_DIG : c_ID_DIGITS)
                                                  : ((LEN_DIG > c_ID_DIGITS) ? LEN_DIG : c_ID_DIGITS);
    localparam int CNT_W    = $clog2(MAX_DIG + 1);

    localparam logic [CNT_W-1:0] c_ID_LAST  = CNT_W'(c_ID_DIGITS - 1);
    localparam logic [CNT_W-1:0] c_LEN_LAST = CNT_W'(LEN_DIG - 1);
    localparam logic [CNT_W-1:0] c_SHA_LAST = CNT_W'(SHA_DIG - 1);

    fmt_state_t          r_state;
    logic                r_tvalid;
    logic                r_first;
    logic [CNT_W-1:0]    r_cnt;
    logic [SHR_BITS-1:0] r_shr;
    logic                r_overflow;
    logic [15:0]         r_drop_cnt;

    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_fire;
    logic [REC_BITS-1:0] w_rdata;
    logic [SHR_BITS-1:0] w_rec_pad;
    logic [SHR_BITS-1:0] w_src;
    logic [SHR_BITS-1:0] w_shifted;
    logic [3:0]          w_nib;
    logic [7:0]          w_tdata;
    logic                w_tlast;

    sha_result_fifo #(
        .WIDTH      (REC_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.ivalid),
        .wdata ({bus.iid, bus.ilen, bus.isha}),
        .pop   (w_pop),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    // Length is zero-extended to whole nibbles so every field shifts out 4 bits at a time
    assign w_rec_pad = {w_rdata[REC_BITS-1 -: c_ID_BITS],
                        LEN_PAD'(w_rdata[SHA_BITS +: LEN_BITS]),
                        w_rdata[SHA_BITS-1:0]};

    // The first digit of a line comes straight from the FIFO read register so a
    // back-to-back line needs no reload bubble; later digits come from the shifter.
    assign w_src     = r_first ? w_rec_pad : r_shr;
    assign w_shifted = {w_src[SHR_BITS-5:0], 4'h0};
    assign w_nib     = w_src[SHR_BITS-1 -: 4];
    assign w_fire    = r_tvalid & bus.m_tready;
    assign w_pop     = ~w_empty & ((r_state == ST_IDLE) | ((r_state == ST_LF) & w_fire));

    // Line formatter: walks the fields, advancing only on accepted bytes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_tvalid <= 1'b0;
            r_first  <= 1'b0;
            r_cnt    <= '0;
            r_shr    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_ID;
                        r_cnt   <= c_ID_LAST;
                        r_first <= 1'b1;
                    end
                end
                ST_ID: begin
                    if (!r_tvalid) begin
                        r_tvalid <= 1'b1;       // read data has now landed
                    end else if (w_fire) begin
                        r_shr   <= w_shifted;
                        r_first <= 1'b0;
                        if (r_cnt == '0) r_state <= ST_SP1;
                        else             r_cnt   <= r_cnt - 1'b1;
                    end
                end
                ST_SP1: begin
                    if (w_fire) begin
                        r_state <= ST_LEN;
                        r_cnt   <= c_LEN_LAST;
                    end
                end
                ST_LEN: begin
                    if (w_fire) begin
                        r_shr <= w_shifted;
                        if (r_cnt == '0) r_state <= ST_SP2;
                        else             r_cnt   <= r_cnt - 1'b1;
                    end
                end
                ST_SP2: begin
                    if (w_fire) begin
                        r_state <= ST_SHA;
                        r_cnt   <= c_SHA_LAST;
                    end
                end
                ST_SHA: begin
                    if (w_fire) begin
                        r_shr <= w_shifted;
                        if (r_cnt == '0) r_state <= ST_CR;
                        else             r_cnt   <= r_cnt - 1'b1;
                    end
                end
                ST_CR: begin
                    if (w_fire) r_state <= ST_LF;
                end
                ST_LF: begin
                    if (w_fire) begin
                        if (!w_empty) begin
                            r_state <= ST_ID;
                            r_cnt   <= c_ID_LAST;
                            r_first <= 1'b1;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_tvalid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tvalid <= 1'b0;
                end
            endcase
        end
    end

    // Byte decode from the registered state; held constant while stalled
    always_comb begin
        w_tdata = 8'h00;
        w_tlast = 1'b0;
        if (r_tvalid) begin
            case (r_state)
                ST_ID, ST_LEN, ST_SHA: w_tdata = hex_ascii(w_nib);
                ST_SP1, ST_SP2:        w_tdata = c_ASCII_SP;
                ST_CR:                 w_tdata = c_ASCII_CR;
                ST_LF: begin
                    w_tdata = c_ASCII_LF;
                    w_tlast = 1'b1;
                end
                default:               w_tdata = 8'h00;
            endcase
        end
    end

    // Drop accounting: full is judged before the edge, so a same-cycle pop does not help
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (bus.ivalid && w_full) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign bus.m_tvalid = r_tvalid;
    assign bus.m_tdata  = w_tdata;
    assign bus.m_tlast  = w_tlast;
    assign overflow     = r_overflow;
    assign drop_cnt     = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sha_result_hex_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha_result_hex_tx
//  Description : Scoreboard bench for sha_result_hex_tx: expected lines are
//                queued at stimulus time, a monitor checks every accepted byte.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sha_result_hex_tx;
    localparam int SHA_BITS   = 256;
    localparam int LEN_BITS   = 61;
    localparam int DEPTH_LOG2 = 2;

    localparam logic [SHA_BITS-1:0] SHA_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam string LINE_ABC =
        "00000111 0000000000000003 ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad\r\n";
    localparam string LINE_LENMAX =
        "5a5a0005 1fffffffffffffff deadbeefdeadbeefdeadbeefdeadbeefdeadbeefdeadbeefdeadbeefdeadbeef\r\n";

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic        overflow;
    logic [15:0] drop_cnt;

    sha_result_hex_tx_if #(.SHA_BITS(SHA_BITS), .LEN_BITS(LEN_BITS)) bus ();

    sha_result_hex_tx #(
        .SHA_BITS   (SHA_BITS),
        .LEN_BITS   (LEN_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests    = 0;
    int          n_fail     = 0;
    int          ready_mode = 1;    // 0 = low, 1 = high, 2 = random
    int          acc_cnt    = 0;
    logic [8:0]  sb_q [$];          // {last, data}
    logic        stall_prev = 1'b0;
    logic [8:0]  held       = '0;

    // Sink ready, changed well after the edge
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       bus.m_tready = 1'b0;
            1:       bus.m_tready = 1'b1;
            default: bus.m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: stall stability plus in-order byte comparison against the queue
    always @(negedge clk) begin
        logic [8:0] exp_b;
        if (!rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_tests++;
                if (!bus.m_tvalid || {bus.m_tlast, bus.m_tdata} != held) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%0b last=%0b data=%02h, need valid=1 last=%0b data=%02h",
                             bus.m_tvalid, bus.m_tlast, bus.m_tdata, held[8], held[7:0]);
                end
            end
            stall_prev = bus.m_tvalid && !bus.m_tready;
            held       = {bus.m_tlast, bus.m_tdata};
            if (bus.m_tvalid && bus.m_tready) begin
                acc_cnt++;
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got data=%02h last=%0b, need no byte",
                             bus.m_tdata, bus.m_tlast);
                end else begin
                    exp_b = sb_q.pop_front();
                    if ({bus.m_tlast, bus.m_tdata} != exp_b) begin
                        n_fail++;
                        $display("FAIL stream_byte: got data=%02h last=%0b, need data=%02h last=%0b",
                                 bus.m_tdata, bus.m_tlast, exp_b[7:0], exp_b[8]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, need %0h", name, got, exp);
        end
    endtask

    function automatic string fmt_line(input logic [31:0] id, input logic [LEN_BITS-1:0] len,
                                       input logic [SHA_BITS-1:0] sha);
        logic [63:0] len64;
        len64 = {3'b000, len};
        return $sformatf("%08x %016x %064x\r\n", id, len64, sha);
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            c = s[i];
            sb_q.push_back({(i == s.len() - 1), c});
        end
    endtask

    // Present one record for exactly one edge; queue its line when it should be kept
    task automatic send_rec(input logic [31:0] id, input logic [LEN_BITS-1:0] len,
                            input logic [SHA_BITS-1:0] sha, input bit keep, input string line);
        bus.ivalid = 1'b1;
        bus.iid    = id;
        bus.ilen   = len;
        bus.isha   = sha;
        if (keep) push_str((line.len() != 0) ? line : fmt_line(id, len, sha));
        @(posedge clk);
        #1;
        bus.ivalid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d bytes outstanding, need 0", name, sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
        check({name, "_idle"}, 32'(bus.m_tvalid), 32'd0);
    endtask

    initial begin
        bus.ivalid = 1'b0;
        bus.iid    = '0;
        bus.ilen   = '0;
        bus.isha   = '0;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid",   32'(bus.m_tvalid), 32'd0);
        check("rst_tdata",    32'(bus.m_tdata),  32'd0);
        check("rst_tlast",    32'(bus.m_tlast),  32'd0);
        check("rst_overflow", 32'(overflow),     32'd0);
        check("rst_drop_cnt", 32'(drop_cnt),     32'd0);
        @(posedge clk); #1 rstn = 1'b1;

        // 1: single "abc" record, sink always ready
        @(posedge clk); #1;
        send_rec(32'h111, 61'd3, SHA_ABC, 1'b1, LINE_ABC);
        @(negedge clk); check("t1_lat_n0", 32'(bus.m_tvalid), 32'd0);
        @(negedge clk); check("t1_lat_n1", 32'(bus.m_tvalid), 32'd0);
        @(negedge clk);
        check("t1_first_valid", 32'(bus.m_tvalid), 32'd1);
        check("t1_first_byte",  32'(bus.m_tdata),  32'h30);
        repeat (91) @(negedge clk);
        check("t1_last_byte", 32'(bus.m_tdata), 32'h0A);
        check("t1_last_flag", 32'(bus.m_tlast), 32'd1);
        drain("t1", 200);

        // 2: same record with a random sink
        @(posedge clk); #1 ready_mode = 2;
        send_rec(32'h111, 61'd3, SHA_ABC, 1'b1, LINE_ABC);
        drain("t2", 2000);
        @(posedge clk); #1 ready_mode = 1;

        // 3: line stalled in progress, then 1..5 back-to-back into a 4-deep FIFO
        @(posedge clk); #1 ready_mode = 0;
        @(posedge clk); #1;
        send_rec(32'hA0, 61'd10, {8{32'h0000_00A0}}, 1'b1, "");
        repeat (3) @(posedge clk); #1;
        for (int i = 1; i <= 5; i++)
            send_rec(32'(i), 61'(i * 7), {8{32'(i)}}, (i <= 4), "");
        @(negedge clk);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
        @(posedge clk); #1 ready_mode = 1;
        drain("t3", 2000);

        // 4: FIFO full while the LF of the current line is accepted
        @(posedge clk); #1 ready_mode = 0;
        @(posedge clk); #1;
        send_rec(32'hB0, 61'd20, {8{32'h0000_00B0}}, 1'b1, "");
        repeat (3) @(posedge clk); #1;
        for (int i = 1; i <= 4; i++)
            send_rec(32'hC100_0000 + 32'(i), 61'(i), {8{32'hCC00_0000 + 32'(i)}}, 1'b1, "");
        ready_mode = 1;
        repeat (91) @(posedge clk);
        @(negedge clk);
        check("t4_lf_shown", 32'({bus.m_tlast, bus.m_tready}), 32'h3);
        send_rec(32'hD0, 61'd1, {8{32'h0000_00D0}}, 1'b0, "");
        @(negedge clk);
        check("t4_no_gap_valid", 32'(bus.m_tvalid), 32'd1);
        check("t4_no_gap_byte",  32'(bus.m_tdata),  32'h63);
        check("t4_drop_cnt",     32'(drop_cnt),     32'd2);
        check("t4_overflow",     32'(overflow),     32'd1);
        drain("t4", 2000);

        // 5: maximum length value
        @(posedge clk); #1;
        send_rec(32'h5a5a0005, 61'h1FFF_FFFF_FFFF_FFFF, {8{32'hdeadbeef}}, 1'b1, LINE_LENMAX);
        drain("t5", 300);

        // 6: reset in the middle of a line
        @(posedge clk); #1;
        acc_cnt = 0;
        send_rec(32'h666, 61'd40, {8{32'h1234_5678}}, 1'b1, "");
        repeat (42) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("t6_bytes_before", 32'(acc_cnt),      32'd40);
        check("t6_rst_tvalid",   32'(bus.m_tvalid), 32'd0);
        check("t6_rst_overflow", 32'(overflow),     32'd0);
        check("t6_rst_drop_cnt", 32'(drop_cnt),     32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_quiet", 32'(bus.m_tvalid), 32'd0);
        @(posedge clk); #1;
        send_rec(32'h777, 61'd64, {8{32'h0F1E_2D3C}}, 1'b1, "");
        drain("t6", 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop if something wedges the flow above
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, need finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
